game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl_if.sv | 24 ++
 rtl/game_ctrl.sv | 145 ++++++++++++++
 tb/tb_game_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - game controller signal bundle: game-step inputs and status outputs
interface game_ctrl_if;
    logic        tick;
    logic        start_key;
    logic        brick_hit;
    logic [9:0]  ball_y;
    logic [8:0]  brick_total;
    logic        run;
    logic        serve;
    logic [2:0]  state;
    logic [2:0]  lives;
    logic [8:0]  bricks_left;
    logic [15:0] score_bcd;

    modport master (
        output tick, start_key, brick_hit, ball_y, brick_total,
        input  run, serve, state, lives, bricks_left, score_bcd
    );

    modport slave (
        input  tick, start_key, brick_hit, ball_y, brick_total,
        output run, serve, state, lives, bricks_left, score_bcd
    );
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - breakout game sequencer: serve/play/over/win, lives, bricks and BCD score
module game_ctrl #(
    parameter int LIVES       = 3,
    parameter int FLOOR_Y     = 470,
    parameter int SERVE_TICKS = 32
) (
    input  logic        clk,
    input  logic        rst,
    game_ctrl_if.slave  gif
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);
    localparam logic [9:0] FLOOR      = 10'(FLOOR_Y);
    localparam logic [2:0] LIVES_INIT = 3'(LIVES);

    state_t      state_q, state_d;
    logic        run_q, run_d;
    logic        serve_q, serve_d;
    logic [2:0]  lives_q, lives_d;
    logic [8:0]  bricks_q, bricks_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        start_q, start_d;
    logic        armed_q, armed_d;
    logic        start_pe;
    logic [8:0]  bricks_nx;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // armed_q masks the first clk after reset so a key held through reset is not an edge
    assign start_pe = gif.start_key & ~start_q & armed_q;

    always_comb begin
        state_d   = state_q;
        serve_d   = 1'b0;
        lives_d   = lives_q;
        bricks_d  = bricks_q;
        score_d   = score_q;
        cnt_d     = cnt_q;
        start_d   = gif.start_key;
        armed_d   = 1'b1;
        bricks_nx = bricks_q;
        if (gif.brick_hit && bricks_q != 9'd0) begin
            bricks_nx = bricks_q - 9'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (start_pe) begin
                    state_d  = S_SERVE;
                    lives_d  = LIVES_INIT;
                    score_d  = 16'h0000;
                    bricks_d = gif.brick_total;
                    serve_d  = 1'b1;
                    cnt_d    = 8'd0;
                end
            end
            S_SERVE: begin
                if (gif.tick) begin
                    if (cnt_q == SERVE_LAST) state_d = S_PLAY;
                    else                     cnt_d   = cnt_q + 8'd1;
                end
            end
            S_PLAY: begin
                if (gif.tick) begin
                    bricks_d = bricks_nx;
                    if (gif.brick_hit) score_d = bcd_inc(score_q);
                    // an empty field wins even when the same step also missed
                    if (bricks_nx == 9'd0) begin
                        state_d = S_WIN;
                    end else if (gif.ball_y >= FLOOR) begin
                        lives_d = lives_q - 3'd1;
                        if (lives_q == 3'd1) begin
                            state_d = S_OVER;
                        end else begin
                            state_d = S_SERVE;
                            serve_d = 1'b1;
                            cnt_d   = 8'd0;
                        end
                    end
                end
            end
            S_OVER, S_WIN: begin
                if (start_pe) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        run_d = (state_d == S_PLAY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            run_q    <= 1'b0;
            serve_q  <= 1'b0;
            lives_q  <= 3'd0;
            bricks_q <= 9'd0;
            score_q  <= 16'h0000;
            cnt_q    <= 8'd0;
            start_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            serve_q  <= serve_d;
            lives_q  <= lives_d;
            bricks_q <= bricks_d;
            score_q  <= score_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            armed_q  <= armed_d;
        end
    end

    assign gif.state       = state_q;
    assign gif.run         = run_q;
    assign gif.serve       = serve_q;
    assign gif.lives       = lives_q;
    assign gif.bricks_left = bricks_q;
    assign gif.score_bcd   = score_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed vector bench for game_ctrl
module tb_game_ctrl;
    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    game_ctrl_if gif();

    game_ctrl #(.LIVES(3), .FLOOR_Y(470), .SERVE_TICKS(32)) dut (
        .clk (clk),
        .rst (rst),
        .gif (gif)
    );

    typedef struct {
        int          rep;
        logic        tk;
        logic        st;
        logic        hit;
        logic [9:0]  y;
        logic [8:0]  tot;
        logic [2:0]  e_state;
        logic        e_run;
        logic        e_serve;
        logic [2:0]  e_lives;
        logic [8:0]  e_bricks;
        logic [15:0] e_score;
    } rec_t;

    rec_t vec[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic add(input int rep, input int tk, input int st, input int hit, input int y,
                       input int tot, input int es, input int er, input int esv, input int el,
                       input int eb, input int esc);
        rec_t r;
        r.rep      = rep;
        r.tk       = 1'(tk);
        r.st       = 1'(st);
        r.hit      = 1'(hit);
        r.y        = 10'(y);
        r.tot      = 9'(tot);
        r.e_state  = 3'(es);
        r.e_run    = 1'(er);
        r.e_serve  = 1'(esv);
        r.e_lives  = 3'(el);
        r.e_bricks = 9'(eb);
        r.e_score  = 16'(esc);
        vec.push_back(r);
    endtask

    task automatic step(input int tk, input int st, input int hit, input int y);
        gif.tick      = 1'(tk);
        gif.start_key = 1'(st);
        gif.brick_hit = 1'(hit);
        gif.ball_y    = 10'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int es, input int er, input int esv, input int el,
                       input int eb, input int esc);
        nvec++;
        if (gif.state !== 3'(es) || gif.run !== 1'(er) || gif.serve !== 1'(esv) ||
            gif.lives !== 3'(el) || gif.bricks_left !== 9'(eb) || gif.score_bcd !== 16'(esc)) begin
            nerr++;
            $display("FAIL %s: got state=%0d run=%0b serve=%0b lives=%0d bricks=%0d score=%h, want state=%0d run=%0b serve=%0b lives=%0d bricks=%0d score=%h",
                     nm, gif.state, gif.run, gif.serve, gif.lives, gif.bricks_left, gif.score_bcd,
                     es, er, esv, el, eb, 16'(esc));
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst  = 1'b0;
        gif.tick = 1'b0; gif.start_key = 1'b0; gif.brick_hit = 1'b0;
        gif.ball_y = 10'd0; gif.brick_total = 9'd6;

        //   rep tk st hit  y   tot  state run serve lives bricks score
        add(  1, 1, 0, 1, 100, 6,   0, 0, 0, 0, 0, 'h0);
        add(  1, 1, 1, 0, 100, 6,   1, 0, 1, 3, 6, 'h0);
        add(  1, 0, 1, 1, 100, 6,   1, 0, 0, 3, 6, 'h0);
        add(  1, 1, 0, 1, 100, 6,   1, 0, 0, 3, 6, 'h0);
        add( 30, 1, 0, 1, 100, 6,   1, 0, 0, 3, 6, 'h0);
        add(  1, 1, 0, 0, 100, 6,   2, 1, 0, 3, 6, 'h0);
        add(  1, 0, 0, 1, 100, 6,   2, 1, 0, 3, 6, 'h0);
        add(  1, 1, 0, 1, 100, 6,   2, 1, 0, 3, 5, 'h1);
        add(  1, 1, 1, 0, 100, 6,   2, 1, 0, 3, 5, 'h1);
        add(  1, 1, 0, 0, 470, 6,   1, 0, 1, 2, 5, 'h1);
        add(  1, 1, 0, 0, 100, 6,   1, 0, 0, 2, 5, 'h1);
        add( 30, 1, 0, 0, 100, 6,   1, 0, 0, 2, 5, 'h1);
        add(  1, 1, 0, 0, 100, 6,   2, 1, 0, 2, 5, 'h1);
        add(  1, 1, 0, 1, 470, 6,   1, 0, 1, 1, 4, 'h2);
        add( 32, 1, 0, 0, 100, 6,   2, 1, 0, 1, 4, 'h2);
        add(  1, 1, 0, 0, 479, 6,   3, 0, 0, 0, 4, 'h2);
        add(  1, 1, 0, 1, 479, 6,   3, 0, 0, 0, 4, 'h2);
        add(  1, 1, 1, 0, 100, 6,   0, 0, 0, 0, 4, 'h2);
        add(  1, 1, 0, 0, 100, 1,   0, 0, 0, 0, 4, 'h2);
        add(  1, 1, 1, 0, 100, 1,   1, 0, 1, 3, 1, 'h0);
        add( 32, 1, 0, 0, 100, 1,   2, 1, 0, 3, 1, 'h0);
        add(  1, 1, 0, 1, 475, 1,   4, 0, 0, 3, 0, 'h1);
        add(  1, 1, 0, 1, 475, 1,   4, 0, 0, 3, 0, 'h1);
        add(  1, 1, 1, 0, 100, 0,   0, 0, 0, 3, 0, 'h1);
        add(  1, 1, 0, 0, 100, 0,   0, 0, 0, 3, 0, 'h1);
        add(  1, 1, 1, 0, 100, 0,   1, 0, 1, 3, 0, 'h0);
        add( 32, 1, 0, 0, 100, 0,   2, 1, 0, 3, 0, 'h0);
        add(  1, 1, 0, 0, 100, 0,   4, 0, 0, 3, 0, 'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 0, 0, 0, 0, 0, 'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vec[i]) begin
            gif.brick_total = vec[i].tot;
            for (int r = 0; r < vec[i].rep; r++) step(vec[i].tk, vec[i].st, vec[i].hit, vec[i].y);
            chk($sformatf("vec%0d", i), vec[i].e_state, vec[i].e_run, vec[i].e_serve,
                vec[i].e_lives, vec[i].e_bricks, vec[i].e_score);
        end

        // BCD carry and saturation in a long game
        step(0, 0, 0, 100);
        step(0, 1, 0, 100);
        step(0, 0, 0, 100);
        gif.brick_total = 9'd200;
        step(0, 1, 0, 100);
        chk("bcd_serve", 1, 0, 1, 3, 200, 'h0);
        repeat (32) step(1, 0, 0, 100);
        chk("bcd_play", 2, 1, 0, 3, 200, 'h0);
        repeat (9) step(1, 0, 1, 100);
        chk("bcd_0009", 2, 1, 0, 3, 191, 'h0009);
        step(1, 0, 1, 100);
        chk("bcd_0010", 2, 1, 0, 3, 190, 'h0010);
        repeat (89) step(1, 0, 1, 100);
        chk("bcd_0099", 2, 1, 0, 3, 101, 'h0099);
        step(1, 0, 1, 100);
        chk("bcd_0100", 2, 1, 0, 3, 100, 'h0100);
        #2;
        force dut.score_q = 16'h9998;
        #1;
        release dut.score_q;
        step(1, 0, 1, 100);
        chk("bcd_9999", 2, 1, 0, 3, 99, 'h9999);
        step(1, 0, 1, 100);
        chk("bcd_saturate", 2, 1, 0, 3, 98, 'h9999);

        // asynchronous reset mid-game, then key held across release
        #2;
        rst = 1'b0;
        #1;
        chk("reset_async_a", 0, 0, 0, 0, 0, 'h0);
        @(negedge clk);
        rst = 1'b1;
        gif.brick_total = 9'd100;
        step(0, 0, 0, 100);
        step(0, 1, 0, 100);
        repeat (32) step(1, 0, 0, 100);
        repeat (42) step(1, 0, 1, 100);
        chk("pre_reset_play", 2, 1, 0, 3, 58, 'h0042);
        #2;
        rst = 1'b0;
        #1;
        chk("reset_async_b", 0, 0, 0, 0, 0, 'h0);
        gif.start_key = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(1, 1, 0, 100);
        chk("key_held_release", 0, 0, 0, 0, 0, 'h0);
        step(1, 0, 0, 100);
        step(1, 1, 0, 100);
        chk("restart_after_reset", 1, 0, 1, 3, 100, 'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
